// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the data cache: word/address typedefs, the
// controller state encoding and the address split as a function of SETS.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;
  localparam int BLK_OFF_W  = 1;

  function automatic int dc_idx_w(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  function automatic int dc_tag_w(input int sets);
    return WORD_W - BYTE_OFF_W - BLK_OFF_W - dc_idx_w(sets);
  endfunction

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE
  } dcache_state_t;

endpackage

// File: rtl/cache_control_if.sv
// Cache <-> memory controller bundle, one slot per CPU.
interface cache_control_if #(parameter int CPUS = 1);
  import cpu_types_pkg::*;

  logic  [CPUS-1:0] dwait, dREN, dWEN;
  word_t [CPUS-1:0] dload, daddr, dstore;

  modport dcache (
    input  dwait, dload,
    output dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/datapath_cache_if.sv
// Datapath <-> data cache request/response bundle.
interface datapath_cache_if;
  import cpu_types_pkg::*;

  logic  dmemREN, dmemWEN, halt;
  logic  dhit, flushed;
  word_t dmemaddr, dmemstore, dmemload;

  modport dcache (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    output dhit, dmemload, flushed
  );
endinterface

// File: rtl/lru_tracker.sv
// True-LRU order per set, kept as a pairwise "more recent than" matrix so that
// the all-zero reset value is itself a legal order (way 0 oldest).
module lru_tracker
  import cpu_types_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8,
  localparam int IDX_W = dc_idx_w(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_set,
  input  logic [WAY_W-1:0] i_way,
  input  logic             i_update,
  output logic [WAY_W-1:0] o_victim
);

  // r_mat[s][i][j] (i<j): 1 means way i was used more recently than way j
  logic [WAYS-1:0][WAYS-1:0] r_mat [SETS];
  logic w_ok, w_found;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) r_mat[s] <= '0;
    end else if (i_update) begin
      for (int i = 0; i < WAYS; i++)
        for (int j = 0; j < WAYS; j++)
          if (i < j) begin
            if (i == int'(i_way))      r_mat[i_set][i][j] <= 1'b1;
            else if (j == int'(i_way)) r_mat[i_set][i][j] <= 1'b0;
          end
    end
  end

  always_comb begin
    o_victim = '0;
    w_found  = 1'b0;
    w_ok     = 1'b0;
    for (int v = 0; v < WAYS; v++) begin
      w_ok = 1'b1;
      for (int j = 0; j < WAYS; j++) begin
        if (j > v)      w_ok = w_ok & ~r_mat[i_set][v][j];
        else if (j < v) w_ok = w_ok &  r_mat[i_set][j][v];
      end
      if (w_ok && !w_found) begin
        w_found  = 1'b1;
        o_victim = WAY_W'(v);
      end
    end
  end

endmodule

// File: rtl/dcache_nway.sv
// N-way write-back, write-allocate data cache with 2-word blocks and halt flush.
// state | meaning: IDLE serve/miss | WB0,WB1 victim writeback | LD0,LD1 fill
//                  FLUSH scan line | FWB0,FWB1 flush writeback | DONE flushed
module dcache_nway
  import cpu_types_pkg::*;
#(
  parameter int CPUID    = 0,
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input logic               CLK,
  input logic               nRST,
  datapath_cache_if.dcache  dcif,
  cache_control_if.dcache   ccif
);

  localparam int IDX_W = dc_idx_w(SETS);
  localparam int TAG_W = dc_tag_w(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  word_t            r_data  [SETS][WAYS][BLKWORDS];

  dcache_state_t    r_state, w_next;
  logic [WAY_W-1:0] r_vway, r_fway;
  logic [IDX_W-1:0] r_idx, r_fset;
  logic [TAG_W-1:0] r_rtag;

  logic [IDX_W-1:0] w_idx, w_lru_set;
  logic [TAG_W-1:0] w_tag;
  logic             w_off, w_req, w_wr, w_halt, w_dwait;
  word_t            w_dload;
  logic             w_hit, w_found_inv, w_vict_dirty, w_fl_dirty, w_flast;
  logic [WAY_W-1:0] w_hit_way, w_vict_way, w_lru_victim, w_lru_way;
  logic             w_dhit, w_flushed, w_miss, w_fill_w0, w_fill_done, w_fclr, w_fadv;
  logic             w_bus_ren, w_bus_wen;
  word_t            w_bus_addr, w_bus_store;
  logic             w_unused_ok;

  assign w_off   = dcif.dmemaddr[2];
  assign w_idx   = dcif.dmemaddr[2+IDX_W:3];
  assign w_tag   = dcif.dmemaddr[31:3+IDX_W];
  assign w_req   = dcif.dmemREN | dcif.dmemWEN;
  assign w_wr    = dcif.dmemWEN;
  assign w_halt  = dcif.halt;
  assign w_dwait = ccif.dwait[CPUID];
  assign w_dload = ccif.dload[CPUID];
  assign w_unused_ok = &{1'b0, dcif.dmemaddr[1:0]};

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
  end

  // Invalid ways are filled first; the LRU order only matters once the set is full.
  always_comb begin
    w_vict_way  = w_lru_victim;
    w_found_inv = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!r_valid[w_idx][w] && !w_found_inv) begin
        w_found_inv = 1'b1;
        w_vict_way  = WAY_W'(w);
      end
  end

  assign w_vict_dirty = r_valid[w_idx][w_vict_way] & r_dirty[w_idx][w_vict_way];
  assign w_fl_dirty   = r_valid[r_fset][r_fway] & r_dirty[r_fset][r_fway];
  assign w_flast      = (r_fset == IDX_W'(SETS-1)) && (r_fway == WAY_W'(WAYS-1));

  assign w_lru_set = (r_state == LD1) ? r_idx  : w_idx;
  assign w_lru_way = (r_state == LD1) ? r_vway : w_hit_way;

  lru_tracker #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_set    (w_lru_set),
    .i_way    (w_lru_way),
    .i_update (w_dhit | w_fill_done),
    .o_victim (w_lru_victim)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_bus_ren   = 1'b0;
    w_bus_wen   = 1'b0;
    w_bus_addr  = '0;
    w_bus_store = '0;
    w_dhit      = 1'b0;
    w_flushed   = 1'b0;
    w_miss      = 1'b0;
    w_fill_w0   = 1'b0;
    w_fill_done = 1'b0;
    w_fclr      = 1'b0;
    w_fadv      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_halt) w_next = FLUSH;
        else if (w_req) begin
          if (w_hit) w_dhit = 1'b1;
          else begin
            w_miss = 1'b1;
            w_next = w_vict_dirty ? WB0 : LD0;
          end
        end
      end
      WB0, WB1: begin
        w_bus_wen   = 1'b1;
        w_bus_addr  = {r_tag[r_idx][r_vway], r_idx, (r_state == WB1), 2'b00};
        w_bus_store = r_data[r_idx][r_vway][(r_state == WB1)];
        if (!w_dwait) w_next = (r_state == WB0) ? WB1 : LD0;
      end
      LD0, LD1: begin
        w_bus_ren  = 1'b1;
        w_bus_addr = {r_rtag, r_idx, (r_state == LD1), 2'b00};
        if (!w_dwait) begin
          w_fill_w0   = (r_state == LD0);
          w_fill_done = (r_state == LD1);
          w_next      = (r_state == LD0) ? LD1 : IDLE;
        end
      end
      FLUSH: begin
        if (w_fl_dirty)   w_next = FWB0;
        else if (w_flast) w_next = DONE;
        else              w_fadv = 1'b1;
      end
      FWB0, FWB1: begin
        w_bus_wen   = 1'b1;
        w_bus_addr  = {r_tag[r_fset][r_fway], r_fset, (r_state == FWB1), 2'b00};
        w_bus_store = r_data[r_fset][r_fway][(r_state == FWB1)];
        if (!w_dwait) begin
          if (r_state == FWB0) w_next = FWB1;
          else begin
            w_fclr = 1'b1;
            w_fadv = !w_flast;
            w_next = w_flast ? DONE : FLUSH;
          end
        end
      end
      DONE:    w_flushed = 1'b1;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
      r_vway <= '0;
      r_idx  <= '0;
      r_rtag <= '0;
      r_fset <= '0;
      r_fway <= '0;
    end else begin
      if (w_miss) begin
        r_vway <= w_vict_way;
        r_idx  <= w_idx;
        r_rtag <= w_tag;
      end
      if (w_dhit && w_wr) r_dirty[w_idx][w_hit_way] <= 1'b1;
      // The victim's old contents are gone once word 0 is overwritten.
      if (w_fill_w0) r_valid[r_idx][r_vway] <= 1'b0;
      if (w_fill_done) begin
        r_valid[r_idx][r_vway] <= 1'b1;
        r_dirty[r_idx][r_vway] <= 1'b0;
      end
      if (w_fclr) r_dirty[r_fset][r_fway] <= 1'b0;
      if (w_fadv) begin
        if (r_fway == WAY_W'(WAYS-1)) begin
          r_fway <= '0;
          r_fset <= r_fset + IDX_W'(1);
        end else begin
          r_fway <= r_fway + WAY_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_dhit && w_wr) r_data[w_idx][w_hit_way][w_off] <= dcif.dmemstore;
    if (w_fill_w0)      r_data[r_idx][r_vway][0] <= w_dload;
    if (w_fill_done) begin
      r_data[r_idx][r_vway][1] <= w_dload;
      r_tag[r_idx][r_vway]     <= r_rtag;
    end
  end

  assign dcif.dhit     = w_dhit;
  assign dcif.dmemload = (w_dhit && !w_wr) ? r_data[w_idx][w_hit_way][w_off] : '0;
  assign dcif.flushed  = w_flushed;

  assign ccif.dREN[CPUID]   = w_bus_ren;
  assign ccif.dWEN[CPUID]   = w_bus_wen;
  assign ccif.daddr[CPUID]  = w_bus_addr;
  assign ccif.dstore[CPUID] = w_bus_store;

endmodule

// File: doc/dcache_nway.md
DCACHE_NWAY -- requirements
Module: dcache_nway

Interface
REQ-001 SHALL have parameter CPUID, default 0, meaning the index into the ccif per-CPU arrays.
REQ-002 SHALL have parameter SETS, default 8, meaning the number of sets (power of 2, 2..64).
REQ-003 SHALL have parameter WAYS, default 2, meaning associativity (1, 2 or 4).
REQ-004 SHALL have parameter BLKWORDS fixed at 2, meaning 32-bit words per block.
REQ-005 SHALL have port CLK, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port nRST, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port dcif, datapath_cache_if.dcache modport, carrying dmemREN, dmemWEN, dmemaddr[31:0], dmemstore[31:0], halt (in) and dhit, dmemload[31:0], flushed (out).
REQ-008 SHALL have port ccif, cache_control_if.dcache modport, carrying dwait[CPUID], dload[CPUID] (in) and dREN[CPUID], dWEN[CPUID], daddr[CPUID], dstore[CPUID] (out).

Function
REQ-009 SHALL split dmemaddr as follows: [1:0] byte, ignored; [2] block offset; [2+log2(SETS):3] index; remaining upper bits tag.
REQ-010 SHALL keep, per way per set: valid, dirty, tag, and 2 data words.
REQ-011 SHALL keep, per set, an age field giving a true LRU order across WAYS.
REQ-012 SHALL assert dhit combinationally in IDLE when (dmemREN or dmemWEN) and any valid way's tag matches.
REQ-012a SHALL drive dmemload with the selected word on a read hit, and 0 otherwise.
REQ-013 SHALL, on a write hit, write dmemstore into the hit word and set dirty at the same clock edge dhit is high.
REQ-014 SHALL update LRU on every hit and fill so that the accessed way becomes most recent.
REQ-015 SHALL select the miss victim as the first invalid way (lowest index), or the LRU way if all ways are valid.
REQ-016 SHALL use states IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE.
REQ-017 SHALL, in IDLE on a miss, go to WB0 if the victim is dirty, else to LD0.
REQ-018 SHALL, in WB0/WB1, drive dWEN=1, daddr={victim tag, index, offset 0/1, 2'b00}, dstore=the victim word, and advance only when dwait=0; WB1 goes to LD0.
REQ-019 SHALL, in LD0/LD1, drive dREN=1, daddr={req tag, index, 0/1, 2'b00}, and latch dload into the victim word when dwait=0.
REQ-019a SHALL, on leaving LD1, set valid=1, dirty=0, and the new tag, then return to IDLE, where the hit occurs.
REQ-020 SHALL drive dREN, dWEN, daddr and dstore to 0 in every state that does not issue a bus request.
REQ-021 SHALL give priority to halt over any new request when halt is sampled in IDLE, and go to FLUSH.
REQ-021a SHALL let an in-flight miss complete before halt is honoured.
REQ-022 SHALL, in FLUSH, scan (set, way) in ascending order via a counter, writing back each valid-dirty line through FWB0/FWB1 (same bus rules as REQ-018) and clearing its dirty bit.
REQ-022a SHALL skip clean or invalid lines at one line per cycle.
REQ-023 SHALL enter DONE after the last line and then hold flushed=1 and dhit=0, ignoring requests, until reset.
REQ-024 SHALL, when dmemREN and dmemWEN are both high, treat the access as a write.
REQ-025 SHALL, on a miss latency from request to dhit, take 2+(2 if dirty) bus transactions plus 1 IDLE cycle; a hit takes 0 cycles.

Reset
REQ-026 SHALL, on nRST low, asynchronously clear all valid, dirty and LRU bits, the flush counter and flushed, and set state to IDLE.
REQ-026a SHALL clear dhit, dREN, dWEN, daddr and dstore to 0 during reset.
REQ-027 SHALL NOT require data and tag arrays to reset.
REQ-028 SHALL, on reset mid-fill or mid-writeback, abandon the transaction immediately with no partial line marked valid.

Structure
REQ-029 SHALL place the state enum dcache_state_t and the address field widths, as functions of SETS, in cpu_types_pkg.
REQ-030 SHALL take word_t and the addr typedefs from cpu_types_pkg.
REQ-031 SHALL implement the LRU tracker as one sub-module lru_tracker (parameters WAYS, SETS; inputs set, way, update; output victim way).

Verification (SETS=8, WAYS=2, memory_control + ram LAT=10)
REQ-032 SHALL verify compulsory miss: load 0x00 from reset -> dREN at daddr 0x00 then 0x04; dhit with RAM[0x00]; then load 0x04 -> dhit same cycle with no dREN.
REQ-033 SHALL verify associativity: load 0x00, 0x40, re-load 0x00, then load 0x80 (same index 0) -> 0x40's way is evicted; a re-load of 0x00 hits and 0x40 misses.
REQ-034 SHALL verify dirty writeback: store 0xDEADBEEF to 0x40, then load 0x80 and 0xC0 -> dWEN at 0x40 with 0xDEADBEEF, then 0x44, before dREN.
REQ-035 SHALL verify flush: dirty lines at 0x08 and 0x18, assert halt -> exactly two 2-word writebacks in ascending set order; flushed=1 afterwards, and RAM holds the stored values.
REQ-036 SHALL verify reset mid-fill: drop nRST during LD1 -> all outputs 0 next sample; re-loading the same address misses again.
REQ-037 SHALL verify simultaneous REN+WEN at 0x00 with 0x1234 -> treated as a store; a later load returns 0x00001234.
